// File: rtl/time_set_ctrl.sv
// time_set_ctrl
// Debounces the "next" and "up" push-buttons and walks the five-state
// RUN / EDIT_HOUR / EDIT_MIN / ALARM_HOUR / ALARM_MIN mode machine that sets
// the clock time and the alarm time.
//
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   next, up                  raw asynchronous push-buttons
//   alarm_on                  alarm enable switch level
//   cur_hour/minute/second    running time from the clock counter
//   load                      one-cycle strobe: counter takes set_hour/set_minute
//   set_hour, set_minute      edited clock time
//   alarm_hour, alarm_minute  stored alarm time
//   disp_hour, disp_minute    time routed to the display
//   blank                     {hour, minute} blink-blank request
//   edit_mode                 high in any non-RUN state
//   alarm_req                 one-cycle alarm trigger pulse
module time_set_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int BLINK_HALF      = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       next,
   input  logic       up,
   input  logic       alarm_on,
   input  logic [5:0] cur_hour,
   input  logic [5:0] cur_minute,
   input  logic [5:0] cur_second,
   output logic       load,
   output logic [5:0] set_hour,
   output logic [5:0] set_minute,
   output logic [5:0] alarm_hour,
   output logic [5:0] alarm_minute,
   output logic [5:0] disp_hour,
   output logic [5:0] disp_minute,
   output logic [1:0] blank,
   output logic       edit_mode,
   output logic       alarm_req
);

   localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int BCW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   typedef enum logic [2:0] {
      S_RUN        = 3'd0,
      S_EDIT_HOUR  = 3'd1,
      S_EDIT_MIN   = 3'd2,
      S_ALARM_HOUR = 3'd3,
      S_ALARM_MIN  = 3'd4
   } state_t;

   // ------------------------------------------------------------------
   // Button conditioning: index 0 = next, index 1 = up
   // ------------------------------------------------------------------
   logic [1:0] raw_btn;
   logic [1:0] press;
   logic       np;
   logic       up_p;

   assign raw_btn = {up, next};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : gen_btn
         logic           sync1_q;
         logic           sync2_q;
         logic           deb_q;
         logic           deb_dly_q;
         logic [DCW-1:0] cnt_q;

         // The debounced level flips only after the synchronized input has
         // disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any
         // agreement in between restarts the count.
         always_ff @(posedge clk) begin
            if (rst) begin
               sync1_q   <= 1'b0;
               sync2_q   <= 1'b0;
               deb_q     <= 1'b0;
               deb_dly_q <= 1'b0;
               cnt_q     <= '0;
            end else begin
               sync1_q   <= raw_btn[gi];
               sync2_q   <= sync1_q;
               deb_dly_q <= deb_q;
               if (sync2_q != deb_q) begin
                  if (cnt_q == DCW'(DEBOUNCE_CYCLES - 1)) begin
                     deb_q <= sync2_q;
                     cnt_q <= '0;
                  end else begin
                     cnt_q <= cnt_q + DCW'(1);
                  end
               end else begin
                  cnt_q <= '0;
               end
            end
         end

         // Press pulse on debounced rising edge only.
         assign press[gi] = deb_q & ~deb_dly_q;
      end
   endgenerate

   assign np   = press[0];
   assign up_p = press[1];

   // ------------------------------------------------------------------
   // Mode FSM and edited registers
   // ------------------------------------------------------------------
   state_t         state_q, state_d;
   logic [5:0]     set_hour_q, set_hour_d;
   logic [5:0]     set_minute_q, set_minute_d;
   logic [5:0]     alarm_hour_q, alarm_hour_d;
   logic [5:0]     alarm_minute_q, alarm_minute_d;
   logic           load_q, load_d;
   logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
   logic           blink_phase_q, blink_phase_d;
   logic [1:0]     blank_q, blank_d;
   logic           edit_mode_q, edit_mode_d;
   logic           match, match_q;
   logic           alarm_req_q;

   function automatic logic [5:0] inc_hour(input logic [5:0] h);
      return (h >= 6'd23) ? 6'd0 : h + 6'd1;
   endfunction

   function automatic logic [5:0] inc_minute(input logic [5:0] m);
      return (m >= 6'd59) ? 6'd0 : m + 6'd1;
   endfunction

   always_comb begin
      state_d        = state_q;
      set_hour_d     = set_hour_q;
      set_minute_d   = set_minute_q;
      alarm_hour_d   = alarm_hour_q;
      alarm_minute_d = alarm_minute_q;
      load_d         = 1'b0;
      // np takes priority: an up_p in the same cycle is dropped.
      case (state_q)
         S_RUN: begin
            if (np) begin
               state_d      = S_EDIT_HOUR;
               set_hour_d   = cur_hour;
               set_minute_d = cur_minute;
            end
         end
         S_EDIT_HOUR: begin
            if (np)        state_d    = S_EDIT_MIN;
            else if (up_p) set_hour_d = inc_hour(set_hour_q);
         end
         S_EDIT_MIN: begin
            if (np) begin
               state_d = S_ALARM_HOUR;
               load_d  = 1'b1;
            end else if (up_p) begin
               set_minute_d = inc_minute(set_minute_q);
            end
         end
         S_ALARM_HOUR: begin
            if (np)        state_d      = S_ALARM_MIN;
            else if (up_p) alarm_hour_d = inc_hour(alarm_hour_q);
         end
         S_ALARM_MIN: begin
            if (np)        state_d        = S_RUN;
            else if (up_p) alarm_minute_d = inc_minute(alarm_minute_q);
         end
         default: state_d = S_RUN;
      endcase
   end

   // Blink phase restarts at every state change and stays 0 in RUN.
   always_comb begin
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (state_d != state_q || state_q == S_RUN) begin
         blink_cnt_d   = '0;
         blink_phase_d = 1'b0;
      end else if (blink_cnt_q == BCW'(BLINK_HALF - 1)) begin
         blink_cnt_d   = '0;
         blink_phase_d = ~blink_phase_q;
      end else begin
         blink_cnt_d = blink_cnt_q + BCW'(1);
      end
   end

   // Registered from next-state so they line up with state_q.
   always_comb begin
      edit_mode_d = (state_d != S_RUN);
      blank_d     = {blink_phase_d & (state_d == S_EDIT_HOUR || state_d == S_ALARM_HOUR),
                     blink_phase_d & (state_d == S_EDIT_MIN  || state_d == S_ALARM_MIN)};
   end

   assign match = (state_q == S_RUN) && alarm_on &&
                  (cur_hour == alarm_hour_q) && (cur_minute == alarm_minute_q) &&
                  (cur_second == 6'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_RUN;
         set_hour_q     <= '0;
         set_minute_q   <= '0;
         alarm_hour_q   <= '0;
         alarm_minute_q <= '0;
         load_q         <= 1'b0;
         blink_cnt_q    <= '0;
         blink_phase_q  <= 1'b0;
         blank_q        <= '0;
         edit_mode_q    <= 1'b0;
         match_q        <= 1'b0;
         alarm_req_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         set_hour_q     <= set_hour_d;
         set_minute_q   <= set_minute_d;
         alarm_hour_q   <= alarm_hour_d;
         alarm_minute_q <= alarm_minute_d;
         load_q         <= load_d;
         blink_cnt_q    <= blink_cnt_d;
         blink_phase_q  <= blink_phase_d;
         blank_q        <= blank_d;
         edit_mode_q    <= edit_mode_d;
         match_q        <= match;
         alarm_req_q    <= match & ~match_q;
      end
   end

   // Display source follows the current mode.
   always_comb begin
      disp_hour   = cur_hour;
      disp_minute = cur_minute;
      case (state_q)
         S_EDIT_HOUR, S_EDIT_MIN: begin
            disp_hour   = set_hour_q;
            disp_minute = set_minute_q;
         end
         S_ALARM_HOUR, S_ALARM_MIN: begin
            disp_hour   = alarm_hour_q;
            disp_minute = alarm_minute_q;
         end
         default: ;
      endcase
   end

   assign load         = load_q;
   assign set_hour     = set_hour_q;
   assign set_minute   = set_minute_q;
   assign alarm_hour   = alarm_hour_q;
   assign alarm_minute = alarm_minute_q;
   assign blank        = blank_q;
   assign edit_mode    = edit_mode_q;
   assign alarm_req    = alarm_req_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with DEBOUNCE_CYCLES=4, BLINK_HALF=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_time_set_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       next;
   logic       up;
   logic       alarm_on;
   logic [5:0] cur_hour;
   logic [5:0] cur_minute;
   logic [5:0] cur_second;
   logic       load;
   logic [5:0] set_hour;
   logic [5:0] set_minute;
   logic [5:0] alarm_hour;
   logic [5:0] alarm_minute;
   logic [5:0] disp_hour;
   logic [5:0] disp_minute;
   logic [1:0] blank;
   logic       edit_mode;
   logic       alarm_req;

   int vectors     = 0;
   int miscompares = 0;
   int load_cnt    = 0;
   int alarm_cnt   = 0;

   time_set_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .BLINK_HALF     (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .next        (next),
      .up          (up),
      .alarm_on    (alarm_on),
      .cur_hour    (cur_hour),
      .cur_minute  (cur_minute),
      .cur_second  (cur_second),
      .load        (load),
      .set_hour    (set_hour),
      .set_minute  (set_minute),
      .alarm_hour  (alarm_hour),
      .alarm_minute(alarm_minute),
      .disp_hour   (disp_hour),
      .disp_minute (disp_minute),
      .blank       (blank),
      .edit_mode   (edit_mode),
      .alarm_req   (alarm_req)
   );

   always #5 clk = ~clk;

   // Pulse counters: values seen during each completed cycle.
   always @(posedge clk) begin
      if (load)      load_cnt  <= load_cnt + 1;
      if (alarm_req) alarm_cnt <= alarm_cnt + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
      $display("vec %0d %s: got %0d expected %0d", vectors, tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input int which, input logic v);
      if (which == 0) next = v;
      else            up   = v;
   endtask

   // Press: after 7 falling edges the action has taken effect.
   task automatic press(input int which);
      drive(which, 1'b1);
      step(7);
   endtask

   task automatic release_btn(input int which);
      drive(which, 1'b0);
      step(7);
   endtask

   task automatic tap(input int which);
      press(which);
      release_btn(which);
   endtask

   initial begin
      int   lc;
      int   ac;
      logic bounce [9];
      logic [1:0] exp_blank;

      bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

      rst = 1'b1; next = 1'b0; up = 1'b0; alarm_on = 1'b0;
      cur_hour = 6'd12; cur_minute = 6'd34; cur_second = 6'd10;
      step(3);
      rst = 1'b0;
      step(1);

      // Reset state
      chk("rst_disp_hour", disp_hour, 12);
      chk("rst_disp_minute", disp_minute, 34);
      chk("rst_edit_mode", edit_mode, 0);
      chk("rst_load", load, 0);
      chk("rst_set_hour", set_hour, 0);
      chk("rst_set_minute", set_minute, 0);
      chk("rst_alarm_hour", alarm_hour, 0);
      chk("rst_alarm_minute", alarm_minute, 0);
      chk("rst_blank", blank, 0);
      chk("rst_alarm_req", alarm_req, 0);
      cur_minute = 6'd35;
      #1;
      chk("run_disp_comb", disp_minute, 35);
      cur_minute = 6'd34;

      // Bouncy next, then stable high: transition exactly 6 cycles later
      for (int i = 0; i < 9; i++) begin
         next = bounce[i];
         step(1);
      end
      chk("bounce_no_edit", edit_mode, 0);
      next = 1'b1;
      step(6);
      chk("press_before_edge", edit_mode, 0);
      step(1);
      chk("press_edit_mode", edit_mode, 1);
      chk("capture_set_hour", set_hour, 12);
      chk("capture_set_minute", set_minute, 34);
      chk("edit_disp_hour", disp_hour, 12);

      // Blink in EDIT_HOUR: 8 cycles off, 8 on, 8 off
      next = 1'b0;
      for (int i = 0; i < 24; i++) begin
         exp_blank = (((i / 8) % 2) == 1) ? 2'b10 : 2'b00;
         chk($sformatf("blink_eh_%0d", i), blank, exp_blank);
         step(1);
      end
      chk("single_transition", edit_mode, 1);

      // 12 ups on hour: 12 -> 23 -> 0
      for (int i = 0; i < 12; i++) begin
         tap(1);
         if (i == 10) chk("set_hour_23", set_hour, 23);
      end
      chk("set_hour_wrap", set_hour, 0);
      chk("disp_hour_wrap", disp_hour, 0);
      chk("set_minute_kept", set_minute, 34);

      // EDIT_MIN: 26 ups, 34 -> 59 -> 0
      tap(0);
      chk("edit_min_mode", edit_mode, 1);
      for (int i = 0; i < 26; i++) begin
         tap(1);
         if (i == 24) chk("set_minute_59", set_minute, 59);
      end
      chk("set_minute_wrap", set_minute, 0);
      chk("no_carry_hour", set_hour, 0);

      // next from EDIT_MIN: single load pulse with 00:00
      lc = load_cnt;
      press(0);
      chk("load_high", load, 1);
      chk("load_set_hour", set_hour, 0);
      chk("load_set_minute", set_minute, 0);
      step(1);
      chk("load_one_cycle", load, 0);
      release_btn(0);
      chk("load_count", load_cnt - lc, 1);

      // Alarm set to 07:05
      for (int i = 0; i < 7; i++) tap(1);
      chk("alarm_hour_7", alarm_hour, 7);
      chk("alarm_disp_hour", disp_hour, 7);
      tap(0);
      for (int i = 0; i < 5; i++) tap(1);
      chk("alarm_minute_5", alarm_minute, 5);
      chk("alarm_disp_minute", disp_minute, 5);
      tap(0);
      chk("back_to_run", edit_mode, 0);
      chk("run_disp_cur", disp_hour, 12);
      chk("set_held", set_minute, 0);

      // Alarm fires once
      alarm_on = 1'b1;
      cur_hour = 6'd7; cur_minute = 6'd4; cur_second = 6'd59;
      step(2);
      ac = alarm_cnt;
      cur_minute = 6'd5; cur_second = 6'd0;
      step(1);
      chk("alarm_req_high", alarm_req, 1);
      step(1);
      chk("alarm_req_one_cycle", alarm_req, 0);
      cur_second = 6'd1;
      step(2);
      chk("alarm_count_1", alarm_cnt - ac, 1);

      // alarm_on = 0: no pulse
      alarm_on = 1'b0;
      cur_minute = 6'd4; cur_second = 6'd59;
      step(2);
      ac = alarm_cnt;
      cur_minute = 6'd5; cur_second = 6'd0;
      step(3);
      chk("alarm_off_no_req", alarm_cnt - ac, 0);

      // Editing suppresses alarm
      alarm_on = 1'b1;
      cur_minute = 6'd4; cur_second = 6'd59;
      tap(0);
      chk("edit2_mode", edit_mode, 1);
      ac = alarm_cnt;
      cur_minute = 6'd5; cur_second = 6'd0;
      step(3);
      chk("edit_no_alarm", alarm_cnt - ac, 0);
      chk("edit2_disp_minute", disp_minute, 4);
      cur_second = 6'd30;
      tap(0);

      // Simultaneous next and up in EDIT_MIN
      lc = load_cnt;
      next = 1'b1; up = 1'b1;
      step(7);
      chk("simul_edit_mode", edit_mode, 1);
      chk("simul_load", load, 1);
      chk("simul_set_minute", set_minute, 4);
      chk("simul_set_hour", set_hour, 7);
      chk("simul_disp_alarm", disp_minute, 5);
      next = 1'b0; up = 1'b0;
      step(7);
      chk("simul_alarm_hour", alarm_hour, 7);
      chk("simul_load_count", load_cnt - lc, 1);

      // Back to RUN, then into EDIT_MIN again
      cur_hour = 6'd10; cur_minute = 6'd20; cur_second = 6'd30;
      tap(0);
      tap(0);
      chk("run_again", edit_mode, 0);
      tap(0);
      tap(0);
      chk("edit_min_again", disp_hour, 10);

      // Reset in the cycle the np pulse is live
      lc = load_cnt;
      next = 1'b1;
      step(6);
      rst = 1'b1;
      step(1);
      chk("rst_load_cancel", load, 0);
      next = 1'b0;
      step(2);
      rst = 1'b0;
      step(10);
      chk("rst_mid_edit_mode", edit_mode, 0);
      chk("rst_mid_load_count", load_cnt - lc, 0);
      chk("rst_mid_alarm_hour", alarm_hour, 0);
      chk("rst_mid_alarm_minute", alarm_minute, 0);
      chk("rst_mid_set_hour", set_hour, 0);
      chk("rst_mid_set_minute", set_minute, 0);
      chk("rst_mid_disp_minute", disp_minute, 20);
      chk("rst_mid_blank", blank, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Controller that sequences the clock datapath's time-set and alarm-set modes. It debounces the `next` and `up` push-buttons and walks a five-state mode FSM. It issues a one-cycle load strobe carrying the new hour/minute to the clock counter, holds the alarm time, and selects which hour/minute the display shows and which field blinks. It sits between the board buttons and the clock, display and alarm/sound blocks in the top-level state machine.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz).
- `BLINK_HALF`, default 50_000_000: cycles per blink half-period (0.5 s at 100 MHz).

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: reset, synchronous and active-high.
- `next` in 1: raw asynchronous "advance field" button.
- `up` in 1: raw asynchronous "increment field" button.
- `alarm_on` in 1: alarm enable switch level.
- `cur_hour` in 6: running hour from the clock counter (0–23).
- `cur_minute` in 6: running minute from the clock counter (0–59).
- `cur_second` in 6: running second from the clock counter (0–59).
- `load` out 1: one-cycle strobe; the clock counter takes `set_hour`/`set_minute` and zeroes seconds.
- `set_hour` out 6: edited hour.
- `set_minute` out 6: edited minute.
- `alarm_hour` out 6: stored alarm hour.
- `alarm_minute` out 6: stored alarm minute.
- `disp_hour` out 6: hour value routed to the display.
- `disp_minute` out 6: minute value routed to the display.
- `blank` out 2: {hour, minute} digit-blank request for blinking.
- `edit_mode` out 1: high in any non-RUN state.
- `alarm_req` out 1: one-cycle alarm trigger pulse to the sound/alarm block.

## Operation
- Button conditioning, applied to `next` and `up` independently:
  - Two-flop synchronizer feeds a stability counter.
  - The debounced level changes only after the synchronized value differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any bounce restarts the count.
  - A press pulse (`np`/`up_p`) is generated on the debounced 0→1 transition only. Release generates nothing.
- FSM states: RUN, EDIT_HOUR, EDIT_MIN, ALARM_HOUR, ALARM_MIN. Transitions occur on `np` only:
  - RUN→EDIT_HOUR: `set_hour`/`set_minute` capture `cur_hour`/`cur_minute`.
  - EDIT_HOUR→EDIT_MIN.
  - EDIT_MIN→ALARM_HOUR: `load` pulses high for exactly this one cycle.
  - ALARM_HOUR→ALARM_MIN.
  - ALARM_MIN→RUN.
- `up_p` increments the field being edited:
  - EDIT_HOUR acts on `set_hour`; EDIT_MIN on `set_minute`; ALARM_HOUR on `alarm_hour`; ALARM_MIN on `alarm_minute`.
  - Hour wraps 23→0. Minute wraps 59→0.
  - No carry between fields.
  - `up_p` in RUN is ignored.
- Simultaneous `np` and `up_p` in the same cycle: `np` wins and `up_p` is discarded.
- Display mux:
  - RUN and EDIT_*: edit/cur values are shown. In RUN, `disp_*` = `cur_*`; in EDIT_*, `disp_*` = `set_*`.
  - ALARM_*: `disp_*` = `alarm_*`.
- Blink:
  - The phase counter clears on every state entry.
  - `blink_phase` toggles every `BLINK_HALF` cycles while in any edit state; it is 0 in RUN.
  - `blank[1]` = `blink_phase` & (EDIT_HOUR or ALARM_HOUR).
  - `blank[0]` = `blink_phase` & (EDIT_MIN or ALARM_MIN).
- Alarm:
  - The match condition is state==RUN & `alarm_on` & `cur_hour`==`alarm_hour` & `cur_minute`==`alarm_minute` & `cur_second`==0.
  - `alarm_req` pulses one cycle on the rising edge of the match condition.
  - The alarm is suppressed while editing.
- Reset mid-operation:
  - State returns to RUN and all edit and alarm registers clear to 0.
  - A `load` already in flight is not issued; the clock counter keeps its time.

## Timing
- Reset values: state RUN; `load`=0; `set_hour`=`set_minute`=`alarm_hour`=`alarm_minute`=0; `blank`=0; `edit_mode`=0; `alarm_req`=0; debounced levels 0; all counters 0.
- `disp_*` equals `cur_*` combinationally while in RUN.
- Press latency: with raw stable high from cycle t, the press pulse occurs in cycle t+2+`DEBOUNCE_CYCLES`. State and registers update on the edge ending that cycle.
- `load`, `set_*` and `alarm_*` are registered outputs.
- `set_*` is valid in the same cycle `load` is high and is held until the next RUN→EDIT_HOUR capture.
- `alarm_req` is registered: one cycle after the match condition rises.
- `edit_mode` and `blank` are registered from state and blink phase.

## Test plan
- Reset, then set `DEBOUNCE_CYCLES`=4 and `BLINK_HALF`=8, and hold `cur` at 12:34 → `disp` shows 12:34, `edit_mode`=0, all outputs at their reset values.
- Press `next` with 3-cycle bounce glitches, then stable → exactly one transition to EDIT_HOUR, `set_hour`=12, `set_minute`=34, and it occurs exactly 6 cycles after the stable level begins.
- In EDIT_HOUR, press `up` 12 times → `set_hour` wraps 23→0. In EDIT_MIN, press `up` 26 times → `set_minute` = 0 after wrap. Press `next` → single `load` pulse with `set_*`=00:00.
- Alarm set to 07:05 via the ALARM states, back to RUN, `alarm_on`=1, drive `cur` 07:05:00 → `alarm_req` asserted one cycle. With `alarm_on`=0, or in EDIT_HOUR → no pulse.
- In EDIT_MIN, assert `np` and `up_p` in the same cycle → state ALARM_HOUR, `set_minute` unchanged, `load`=1.
- Blink check: in EDIT_HOUR `blank`=10 on alternate 8-cycle windows and `blank[0]`=0 throughout. Assert `rst` mid-EDIT_MIN → RUN, no `load`, `alarm_*`=0.
